// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: result-source encodings, load funct3 codes and
// control-bus bit positions.
package wb_pkg;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam int unsigned CTRL_REGWRITE = 2;
    localparam int unsigned CTRL_SRC_MSB  = 1;
    localparam int unsigned CTRL_SRC_LSB  = 0;

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a raw memory word for sub-word loads.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned word_size = 32
) (
    input  logic [word_size-1:0] raw_i,
    input  logic [2:0]           addr_i,
    input  logic [2:0]           funct3_i,
    output logic [word_size-1:0] ext_o
);

    localparam logic Is64 = (word_size == 64);

    logic [5:0]           byte_sh;
    logic [5:0]           half_sh;
    logic [5:0]           word_sh;
    logic [word_size-1:0] byte_lane;
    logic [word_size-1:0] half_lane;
    logic [word_size-1:0] word_lane;
    logic [7:0]           b;
    logic [15:0]          h;
    logic [31:0]          w;

    // Bit 2 of the address only selects a lane on a 64-bit datapath.
    assign byte_sh   = {addr_i[2] & Is64, addr_i[1:0], 3'b000};
    assign half_sh   = {addr_i[2] & Is64, addr_i[1], 4'b0000};
    assign word_sh   = {addr_i[2] & Is64, 5'b00000};
    assign byte_lane = raw_i >> byte_sh;
    assign half_lane = raw_i >> half_sh;
    assign word_lane = raw_i >> word_sh;
    assign b         = byte_lane[7:0];
    assign h         = half_lane[15:0];
    assign w         = word_lane[31:0];

    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            LB:      ext_o = word_size'($signed(b));
            LBU:     ext_o = word_size'(b);
            LH:      ext_o = word_size'($signed(h));
            LHU:     ext_o = word_size'(h);
            LW:      ext_o = word_size'($signed(w));
            LWU:     ext_o = word_size'(w);
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with stall/flush, result-source mux, load extension, x0 write
// suppression and a retired-instruction counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int unsigned word_size = 32,
    parameter int unsigned reg_size  = 5,
    parameter int unsigned cnt_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [2:0]           wb_control_signals,
    input  logic [2:0]           load_funct3,
    input  logic [word_size-1:0] ReadData,
    input  logic [word_size-1:0] AluResult,
    input  logic [word_size-1:0] LinkAddr,
    input  logic [reg_size-1:0]  destination_reg,
    output logic [reg_size-1:0]  WriteReg,
    output logic [word_size-1:0] WriteData,
    output logic                 RegWrite,
    output logic [cnt_width-1:0] retired_count
);

    logic                 wb_valid_q, wb_valid_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [word_size-1:0] read_data_q, read_data_d;
    logic [word_size-1:0] alu_result_q, alu_result_d;
    logic [word_size-1:0] link_addr_q, link_addr_d;
    logic [reg_size-1:0]  rd_q, rd_d;
    logic [cnt_width-1:0] retired_count_q, retired_count_d;
    logic [word_size-1:0] load_data;

    always_comb begin
        wb_valid_d      = wb_valid_q;
        ctrl_d          = ctrl_q;
        funct3_d        = funct3_q;
        read_data_d     = read_data_q;
        alu_result_d    = alu_result_q;
        link_addr_d     = link_addr_q;
        rd_d            = rd_q;
        retired_count_d = retired_count_q;
        // Flush only kills validity; the data registers are left as they are.
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d      = in_valid;
            ctrl_d          = wb_control_signals;
            funct3_d        = load_funct3;
            read_data_d     = ReadData;
            alu_result_d    = AluResult;
            link_addr_d     = LinkAddr;
            rd_d            = destination_reg;
            retired_count_d = retired_count_q + cnt_width'(in_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q      <= 1'b0;
            ctrl_q          <= '0;
            funct3_q        <= '0;
            read_data_q     <= '0;
            alu_result_q    <= '0;
            link_addr_q     <= '0;
            rd_q            <= '0;
            retired_count_q <= '0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            ctrl_q          <= ctrl_d;
            funct3_q        <= funct3_d;
            read_data_q     <= read_data_d;
            alu_result_q    <= alu_result_d;
            link_addr_q     <= link_addr_d;
            rd_q            <= rd_d;
            retired_count_q <= retired_count_d;
        end
    end

    load_extend #(
        .word_size(word_size)
    ) u_load_extend (
        .raw_i   (read_data_q),
        .addr_i  (alu_result_q[2:0]),
        .funct3_i(funct3_q),
        .ext_o   (load_data)
    );

    always_comb begin
        WriteData = alu_result_q;
        case (ctrl_q[CTRL_SRC_MSB:CTRL_SRC_LSB])
            WB_SRC_MEM:  WriteData = load_data;
            WB_SRC_LINK: WriteData = link_addr_q;
            default:     WriteData = alu_result_q;
        endcase
    end

    assign RegWrite      = wb_valid_q & ctrl_q[CTRL_REGWRITE] & (rd_q != '0);
    assign WriteReg      = rd_q;
    assign retired_count = retired_count_q;

endmodule
